// File: rtl/mem_unit.sv
// Word-addressed memory with its own address/data/command registers and a
// req/busy/done handshake; programmable wait states, byte-lane writes, range check.
module mem_unit #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 11,
   parameter int DEPTH  = 2048,
   parameter int WAIT   = 1
) (
   input  logic                clock,
   input  logic                nReset,
   input  logic                req,
   input  logic                nWrite,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] be,
   output logic [DATA_W-1:0]   rdata,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [1:0]          dbg_state
);

   localparam int NB = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_XFER = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Handshake: a request is taken only when req is high at a rising edge in
   // IDLE; busy stays high until the cycle after the single-cycle done pulse.
   state_t            state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [NB-1:0]     be_q;
   logic              rd_q;

   logic [DATA_W-1:0] mem [0:DEPTH-1];

   logic              in_range;
   logic [IDX_W-1:0]  idx;

   // Full-width compare so addresses that alias in the truncated index are caught.
   assign in_range  = ({1'b0, addr_q} < DEPTH_V);
   assign idx       = addr_q[IDX_W-1:0];
   assign dbg_state = state;

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rd_q    <= 1'b0;
         rdata   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  addr_q  <= addr;
                  wdata_q <= wdata;
                  be_q    <= be;
                  rd_q    <= nWrite;
                  busy    <= 1'b1;
                  if (WAIT == 0) begin
                     state <= S_XFER;
                  end else begin
                     state <= S_WAIT;
                     cnt   <= 4'(WAIT - 1);
                  end
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) state <= S_XFER;
               else             cnt   <= cnt - 4'd1;
            end
            S_XFER: begin
               if (rd_q) rdata <= in_range ? mem[idx] : '0;
               err   <= ~in_range;
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Storage is not reset; a reset before the XFER edge leaves state in IDLE,
   // so an aborted write never reaches the array.
   always_ff @(posedge clock) begin
      if (state == S_XFER && !rd_q && in_range) begin
         for (int i = 0; i < NB; i++) begin
            if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit: three instances (WAIT=1, WAIT=0, DEPTH=1000/WAIT=2),
// vector table, hand-written corner sequences, and a randomized model check.
module tb_mem_unit;

   logic        clock;
   logic        rst_n  [3];
   logic        req    [3];
   logic        nwrite [3];
   logic [10:0] addr   [3];
   logic [15:0] wdata  [3];
   logic [1:0]  be     [3];
   logic [15:0] rdata  [3];
   logic        busy   [3];
   logic        done   [3];
   logic        err    [3];
   logic [1:0]  dbg    [3];

   int wait_of  [3] = '{1, 0, 2};
   int depth_of [3] = '{2048, 2048, 1000};
   int base_of  [3] = '{100, 200, 990};

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] last_rd [3];
   logic [15:0] mdl [int];
   logic [16:0] exp_q [$];

   typedef struct {
      int          k;
      logic        nwr;
      logic [10:0] a;
      logic [15:0] d;
      logic [1:0]  b;
      logic [15:0] exp_rd;
      logic        exp_err;
   } vec_t;
   vec_t tbl [$];

   mem_unit #(.DATA_W(16), .ADDR_W(11), .DEPTH(2048), .WAIT(1)) u_w1 (
      .clock(clock), .nReset(rst_n[0]), .req(req[0]), .nWrite(nwrite[0]),
      .addr(addr[0]), .wdata(wdata[0]), .be(be[0]), .rdata(rdata[0]),
      .busy(busy[0]), .done(done[0]), .err(err[0]), .dbg_state(dbg[0]));

   mem_unit #(.DATA_W(16), .ADDR_W(11), .DEPTH(2048), .WAIT(0)) u_w0 (
      .clock(clock), .nReset(rst_n[1]), .req(req[1]), .nWrite(nwrite[1]),
      .addr(addr[1]), .wdata(wdata[1]), .be(be[1]), .rdata(rdata[1]),
      .busy(busy[1]), .done(done[1]), .err(err[1]), .dbg_state(dbg[1]));

   mem_unit #(.DATA_W(16), .ADDR_W(11), .DEPTH(1000), .WAIT(2)) u_d1k (
      .clock(clock), .nReset(rst_n[2]), .req(req[2]), .nWrite(nwrite[2]),
      .addr(addr[2]), .wdata(wdata[2]), .be(be[2]), .rdata(rdata[2]),
      .busy(busy[2]), .done(done[2]), .err(err[2]), .dbg_state(dbg[2]));

   // clock / watchdog
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   // One full transaction on instance k; inputs are scrambled right after accept.
   task automatic run_op(input int k, input logic nwr, input logic [10:0] a,
                         input logic [15:0] d, input logic [1:0] b,
                         output logic [15:0] rd, output logic er);
      int n;
      n = 0;
      while (busy[k] && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (busy[k]) check("idle_timeout", 32'(busy[k]), 32'd0);
      req[k] = 1'b1; nwrite[k] = nwr; addr[k] = a; wdata[k] = d; be[k] = b;
      @(negedge clock);
      req[k]    = 1'b0;
      addr[k]   = 11'($urandom);
      wdata[k]  = 16'($urandom);
      be[k]     = 2'($urandom);
      nwrite[k] = 1'($urandom);
      n = 0;
      while (!done[k] && n < 40) begin
         @(negedge clock);
         n++;
      end
      check("latency", 32'(n), 32'(wait_of[k] + 1));
      check("busy_at_done", 32'(busy[k]), 32'd1);
      rd = rdata[k];
      er = err[k];
      @(negedge clock);
      check("busy_done_fall", {30'd0, done[k], busy[k]}, 32'd0);
   endtask

   // Behavioural model: per-instance word store keyed by instance and address.
   task automatic model_op(input int k, input logic nwr, input logic [10:0] a,
                           input logic [15:0] d, input logic [1:0] b);
      int key;
      logic [15:0] w;
      bit ok;
      key = k * 4096 + int'(a);
      ok  = int'(a) < depth_of[k];
      if (!nwr) begin
         if (ok) begin
            w = mdl.exists(key) ? mdl[key] : 16'h0000;
            if (b[0]) w = (w & 16'hFF00) | (d & 16'h00FF);
            if (b[1]) w = (w & 16'h00FF) | (d & 16'hFF00);
            mdl[key] = w;
         end
      end else begin
         last_rd[k] = ok ? mdl[key] : 16'h0000;
      end
      exp_q.push_back({~ok, last_rd[k]});
   endtask

   initial begin
      logic [15:0] rd;
      logic        er;
      logic [16:0] e;
      logic [10:0] a;
      logic [15:0] d;
      logic [1:0]  b;
      logic        nwr;

      for (int k = 0; k < 3; k++) begin
         rst_n[k] = 1'b0; req[k] = 1'b0; nwrite[k] = 1'b1;
         addr[k] = '0; wdata[k] = '0; be[k] = '0; last_rd[k] = '0;
      end

      // vector table
      tbl.push_back('{0, 1'b0, 11'd5,    16'hBEEF, 2'b11, 16'h0000, 1'b0});
      tbl.push_back('{0, 1'b1, 11'd5,    16'h0000, 2'b00, 16'hBEEF, 1'b0});
      tbl.push_back('{0, 1'b0, 11'd7,    16'h1234, 2'b11, 16'hBEEF, 1'b0});
      tbl.push_back('{0, 1'b0, 11'd7,    16'hAB00, 2'b10, 16'hBEEF, 1'b0});
      tbl.push_back('{0, 1'b1, 11'd7,    16'h0000, 2'b00, 16'hAB34, 1'b0});
      tbl.push_back('{0, 1'b0, 11'd7,    16'hFFFF, 2'b00, 16'hAB34, 1'b0});
      tbl.push_back('{0, 1'b1, 11'd7,    16'h0000, 2'b00, 16'hAB34, 1'b0});
      tbl.push_back('{0, 1'b0, 11'd3,    16'h0F0F, 2'b11, 16'hAB34, 1'b0});
      tbl.push_back('{0, 1'b0, 11'd20,   16'h7777, 2'b11, 16'hAB34, 1'b0});
      tbl.push_back('{0, 1'b1, 11'd20,   16'h0000, 2'b00, 16'h7777, 1'b0});
      tbl.push_back('{0, 1'b1, 11'd3,    16'h0000, 2'b00, 16'h0F0F, 1'b0});
      tbl.push_back('{1, 1'b0, 11'd2047, 16'hABCD, 2'b11, 16'h0000, 1'b0});
      tbl.push_back('{1, 1'b1, 11'd2047, 16'h0000, 2'b00, 16'hABCD, 1'b0});
      tbl.push_back('{1, 1'b0, 11'd0,    16'h5A5A, 2'b11, 16'hABCD, 1'b0});
      tbl.push_back('{1, 1'b1, 11'd0,    16'h0000, 2'b00, 16'h5A5A, 1'b0});
      tbl.push_back('{2, 1'b0, 11'd476,  16'h1111, 2'b11, 16'h0000, 1'b0});
      tbl.push_back('{2, 1'b1, 11'd476,  16'h0000, 2'b00, 16'h1111, 1'b0});
      tbl.push_back('{2, 1'b1, 11'd1500, 16'h0000, 2'b00, 16'h0000, 1'b1});
      tbl.push_back('{2, 1'b0, 11'd1500, 16'h2222, 2'b11, 16'h0000, 1'b1});
      tbl.push_back('{2, 1'b1, 11'd476,  16'h0000, 2'b00, 16'h1111, 1'b0});
      tbl.push_back('{2, 1'b0, 11'd999,  16'h3C3C, 2'b11, 16'h1111, 1'b0});
      tbl.push_back('{2, 1'b1, 11'd999,  16'h0000, 2'b00, 16'h3C3C, 1'b0});
      tbl.push_back('{2, 1'b1, 11'd1000, 16'h0000, 2'b00, 16'h0000, 1'b1});
      tbl.push_back('{2, 1'b0, 11'd2047, 16'h9999, 2'b10, 16'h0000, 1'b1});
      tbl.push_back('{2, 1'b1, 11'd476,  16'h0000, 2'b00, 16'h1111, 1'b0});

      // reset state
      repeat (2) @(negedge clock);
      for (int k = 0; k < 3; k++) begin
         check("reset_rdata", 32'(rdata[k]), 32'd0);
         check("reset_flags", {29'd0, busy[k], done[k], err[k]}, 32'd0);
         rst_n[k] = 1'b1;
      end
      @(negedge clock);

      foreach (tbl[i]) begin
         run_op(tbl[i].k, tbl[i].nwr, tbl[i].a, tbl[i].d, tbl[i].b, rd, er);
         check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
         check($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
         last_rd[tbl[i].k] = tbl[i].exp_rd;
      end

      // WAIT=0 back-to-back reads with req held high: done every 3rd cycle
      req[1] = 1'b1; nwrite[1] = 1'b1; addr[1] = 11'd2047;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         check($sformatf("b2b_done%0d", i), 32'(done[1]), 32'((i % 3) == 1));
         if (done[1]) check("b2b_rdata", 32'(rdata[1]), 32'h0000ABCD);
      end
      req[1] = 1'b0;
      @(negedge clock);
      last_rd[1] = 16'hABCD;

      // reset during WAIT aborts a write of 0x5555 over 0x0F0F
      req[0] = 1'b1; nwrite[0] = 1'b0; addr[0] = 11'd3; wdata[0] = 16'h5555; be[0] = 2'b11;
      @(negedge clock);
      req[0] = 1'b0;
      #2 rst_n[0] = 1'b0;
      #1;
      check("midrst_rdata", 32'(rdata[0]), 32'd0);
      check("midrst_flags", {30'd0, busy[0], done[0]}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("midrst_no_done", 32'(done[0]), 32'd0);
      end
      rst_n[0] = 1'b1;
      @(negedge clock);
      run_op(0, 1'b1, 11'd3, 16'h0000, 2'b00, rd, er);
      check("midrst_readback", 32'(rd), 32'h00000F0F);
      last_rd[0] = 16'h0F0F;

      // randomized ops against the model
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 20; i++) begin
            a = 11'(base_of[k] + i);
            d = 16'($urandom);
            model_op(k, 1'b0, a, d, 2'b11);
            run_op(k, 1'b0, a, d, 2'b11, rd, er);
            e = exp_q.pop_front();
            check("rand_init", {15'd0, er, rd}, {15'd0, e});
         end
         for (int i = 0; i < 40; i++) begin
            a   = 11'(base_of[k] + $urandom_range(0, 19));
            d   = 16'($urandom);
            b   = 2'($urandom_range(0, 3));
            nwr = 1'($urandom_range(0, 1));
            model_op(k, nwr, a, d, b);
            run_op(k, nwr, a, d, b, rd, er);
            e = exp_q.pop_front();
            check($sformatf("rand_k%0d_a%0d", k, a), {15'd0, er, rd}, {15'd0, e});
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
